// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// synchronous flush and a per-entry occupancy LED map.
// Optional macro FIFO_FWFT_EN selects first-word-fall-through read mode;
// without it reads are registered with one cycle of latency.
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 10,
    parameter int unsigned AFULL_TH  = 8,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [DATA_W-1:0]            i_din,
    input  logic                         i_wr,
    input  logic                         i_rd,
    input  logic                         i_flush,
    input  logic                         i_clr_err,
    output logic [DATA_W-1:0]            o_dout,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty,
    output logic                         o_full,
    output logic                         o_aempty,
    output logic                         o_afull,
    output logic                         o_ovf,
    output logic                         o_udf,
    output logic [DEPTH-1:0]             o_led
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [DEPTH-1:0] led_q,    led_d;
    logic             ovf_q,    ovf_d;
    logic             udf_q,    udf_d;

    logic empty, full, rd_ok, wr_ok;

    // Pointers wrap by explicit compare so DEPTH need not be a power of two
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign rd_ok = i_rd & ~empty;
    assign wr_ok = i_wr & (~full | rd_ok);

    assign o_count  = count_q;
    assign o_empty  = empty;
    assign o_full   = full;
    assign o_aempty = (count_q <= CW'(AEMPTY_TH));
    assign o_afull  = (count_q >= CW'(AFULL_TH));
    assign o_ovf    = ovf_q;
    assign o_udf    = udf_q;
    assign o_led    = led_q;

    // Storage write; contents deliberately survive reset and flush
    always_ff @(posedge i_clk) begin
        if (wr_ok && !i_flush) begin
            mem_q[wr_ptr_q] <= i_din;
        end
    end

    // Next-state for pointers, count, LED map and sticky error flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        led_d    = led_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            led_d    = '0;
        end else begin
            if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (wr_ok && !rd_ok)      count_d = count_q + CW'(1);
            else if (rd_ok && !wr_ok) count_d = count_q - CW'(1);
            // Clear before set so a same-index write keeps its LED lit
            if (rd_ok) led_d[rd_ptr_q] = 1'b0;
            if (wr_ok) led_d[wr_ptr_q] = 1'b1;
            // Clear before set so a fresh error survives a same-cycle clear
            if (i_clr_err) begin
                ovf_d = 1'b0;
                udf_d = 1'b0;
            end
            if (i_wr && !wr_ok) ovf_d = 1'b1;
            if (i_rd && empty)  udf_d = 1'b1;
        end
    end

    // Control state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            led_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            led_q    <= led_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry falls through; a read simply pops it
    always_comb begin
        o_dout  = mem_q[rd_ptr_q];
        o_valid = ~empty;
    end
`else
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;

    // Registered read data; held on underflow and flush
    always_comb begin
        dout_d  = dout_q;
        valid_d = 1'b0;
        if (!i_flush && rd_ok) begin
            dout_d  = mem_q[rd_ptr_q];
            valid_d = 1'b1;
        end
    end

    // Read data/valid register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign o_dout  = dout_q;
    assign o_valid = valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed testbench for sync_fifo_param (DEPTH=10, DATA_W=8).
// Builds with FIFO_FWFT_EN defined exercise the fall-through read path.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       wr, rd, flush, clr;
    logic [7:0] dout;
    logic       valid;
    logic [3:0] count;
    logic       empty, full, aempty, afull, ovf, udf;
    logic [9:0] led;

    int unsigned errors = 0;
    int unsigned checks = 0;

    sync_fifo_param #(
        .DATA_W   (8),
        .DEPTH    (10),
        .AFULL_TH (8),
        .AEMPTY_TH(2)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_din    (din),
        .i_wr     (wr),
        .i_rd     (rd),
        .i_flush  (flush),
        .i_clr_err(clr),
        .o_dout   (dout),
        .o_valid  (valid),
        .o_count  (count),
        .o_empty  (empty),
        .o_full   (full),
        .o_aempty (aempty),
        .o_afull  (afull),
        .o_ovf    (ovf),
        .o_udf    (udf),
        .o_led    (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge
    task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                       input logic f, input logic c);
        wr = w; rd = r; din = d; flush = f; clr = c;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; flush = 1'b0; clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; din = '0; wr = 0; rd = 0; flush = 0; clr = 0;
        #12;
        chk("rst_count",  32'(count),  0);
        chk("rst_empty",  32'(empty),  1);
        chk("rst_full",   32'(full),   0);
        chk("rst_aempty", 32'(aempty), 1);
        chk("rst_afull",  32'(afull),  0);
        chk("rst_led",    32'(led),    0);
        chk("rst_ovf",    32'(ovf),    0);
        chk("rst_udf",    32'(udf),    0);
        chk("rst_valid",  32'(valid),  0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef FIFO_FWFT_EN
        cyc(1, 0, 8'h3C, 0, 0);
        chk("fw_valid1", 32'(valid), 1);
        chk("fw_dout1",  32'(dout),  32'h3C);
        chk("fw_count1", 32'(count), 1);
        cyc(1, 0, 8'h3D, 0, 0);
        chk("fw_dout_hold", 32'(dout), 32'h3C);
        cyc(0, 1, 8'h00, 0, 0);
        chk("fw_pop1_dout",  32'(dout),  32'h3D);
        chk("fw_pop1_valid", 32'(valid), 1);
        cyc(0, 1, 8'h00, 0, 0);
        chk("fw_pop2_valid", 32'(valid), 0);
        chk("fw_pop2_empty", 32'(empty), 1);
        cyc(0, 1, 8'h00, 0, 0);
        chk("fw_udf", 32'(udf), 1);
`else
        // Fill with 0x01..0x0A, tracking count and thresholds
        for (int i = 1; i <= 10; i++) begin
            cyc(1, 0, 8'(i), 0, 0);
            chk("fill_count",  32'(count),  32'(i));
            chk("fill_afull",  32'(afull),  (i >= 8) ? 1 : 0);
            chk("fill_aempty", 32'(aempty), (i <= 2) ? 1 : 0);
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_led",  32'(led),  32'h3FF);
        chk("fill_ovf",  32'(ovf),  0);

        // Overflow and clear
        cyc(1, 0, 8'h55, 0, 0);
        chk("ovf_set",   32'(ovf),   1);
        chk("ovf_count", 32'(count), 10);
        cyc(0, 0, 8'h00, 0, 1);
        chk("ovf_clr", 32'(ovf), 0);

        // Drain in order
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 1, 8'h00, 0, 0);
            chk("drain_valid", 32'(valid), 1);
            chk("drain_dout",  32'(dout),  32'(i));
            chk("drain_count", 32'(count), 32'(10 - i));
        end
        cyc(0, 0, 8'h00, 0, 0);
        chk("drain_valid_off", 32'(valid), 0);
        chk("drain_empty",     32'(empty), 1);
        chk("drain_led",       32'(led),   0);

        // Wrap-around: pointers go 0->7, then writes land at 7,8,9,0,1,2
        for (int i = 0; i < 7; i++) cyc(1, 0, 8'(8'h20 + i), 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 8'h00, 0, 0);
        chk("wrap_pre_dout", 32'(dout), 32'h26);
        for (int i = 0; i < 6; i++) cyc(1, 0, 8'(8'h30 + i), 0, 0);
        chk("wrap_led",   32'(led),   32'h387);
        chk("wrap_count", 32'(count), 6);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 8'h00, 0, 0);
            chk("wrap_dout", 32'(dout), 32'(8'h30 + i));
        end
        chk("wrap_empty", 32'(empty), 1);

        // Full with simultaneous write and read
        for (int i = 0; i < 10; i++) cyc(1, 0, 8'(8'h40 + i), 0, 0);
        chk("fr_full", 32'(full), 1);
        cyc(1, 1, 8'hAA, 0, 0);
        chk("fr_count", 32'(count), 10);
        chk("fr_dout",  32'(dout),  32'h40);
        chk("fr_ovf",   32'(ovf),   0);
        for (int i = 1; i < 10; i++) begin
            cyc(0, 1, 8'h00, 0, 0);
            chk("fr_drain", 32'(dout), 32'(8'h40 + i));
        end
        cyc(0, 1, 8'h00, 0, 0);
        chk("fr_last", 32'(dout),  32'hAA);
        chk("fr_mt",   32'(empty), 1);

        // Empty with simultaneous write and read
        cyc(1, 1, 8'h77, 0, 0);
        chk("er_count", 32'(count), 1);
        chk("er_udf",   32'(udf),   1);
        chk("er_valid", 32'(valid), 0);
        chk("er_dout",  32'(dout),  32'hAA);
        cyc(0, 1, 8'h00, 0, 0);
        chk("er_read", 32'(dout), 32'h77);
        cyc(0, 0, 8'h00, 0, 1);
        chk("udf_clr", 32'(udf), 0);
        cyc(0, 1, 8'h00, 0, 1);
        chk("udf_set_wins", 32'(udf), 1);
        cyc(0, 0, 8'h00, 0, 1);
        chk("udf_clr2", 32'(udf), 0);

        // Flush with 5 entries, concurrent write and read both discarded
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h50 + i), 0, 0);
        chk("fl_led_pre", 32'(led), 32'h3E0);
        cyc(1, 1, 8'h99, 1, 0);
        chk("fl_count", 32'(count), 0);
        chk("fl_empty", 32'(empty), 1);
        chk("fl_led",   32'(led),   0);
        chk("fl_valid", 32'(valid), 0);
        chk("fl_dout",  32'(dout),  32'h77);
        cyc(1, 0, 8'h11, 0, 0);
        chk("fl_ptr_led", 32'(led), 1);
        cyc(0, 1, 8'h00, 0, 0);
        chk("fl_read", 32'(dout), 32'h11);

        // Asynchronous reset mid-burst
        cyc(0, 1, 8'h00, 0, 0);
        chk("ar_udf_pre", 32'(udf), 1);
        cyc(1, 0, 8'h21, 0, 0);
        cyc(1, 0, 8'h22, 0, 0);
        cyc(1, 0, 8'h23, 0, 0);
        cyc(0, 1, 8'h00, 0, 0);
        chk("ar_valid_pre", 32'(valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_count", 32'(count), 0);
        chk("ar_empty", 32'(empty), 1);
        chk("ar_led",   32'(led),   0);
        chk("ar_valid", 32'(valid), 0);
        chk("ar_dout",  32'(dout),  0);
        chk("ar_udf",   32'(udf),   0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
